bpred: RTL and testbench

Bimodal branch predictor paired with the branch comparison unit: the fetch stage queries it with the current PC and receives a taken/not-taken prediction plus a target one cycle later. The execute stage writes back each resolved conditional-branch outcome from the comparison unit to train it. A 2-bit saturating-counter table (BHT) and a tagged branch target buffer (BTB) are cleared by a post-reset sweep state machine before predictions are served.

---
 rtl/bpred.sv | 111 +++++++++++
 tb/tb_bpred.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bpred.sv
// Bimodal branch predictor: 2-bit saturating BHT plus tagged BTB, cleared by a post-reset sweep.
// Predictions return one cycle after an accepted request; updates train on the sampling edge.
module bpred #(
  parameter int unsigned BHT_DEPTH = 6,
  parameter int unsigned BTB_DEPTH = 5
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        pred_valid_i,
  input  logic [31:0] pred_pc_i,
  output logic        pred_ready_o,
  output logic        pred_out_valid_o,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int unsigned CntW = (BHT_DEPTH > BTB_DEPTH) ? BHT_DEPTH : BTB_DEPTH;
  localparam int unsigned BhtN = 1 << BHT_DEPTH;
  localparam int unsigned BtbN = 1 << BTB_DEPTH;
  localparam int unsigned TagW = 31 - BTB_DEPTH;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              pred_out_valid_q;
  logic              pred_taken_q;
  logic [31:0]       pred_target_q;

  logic [1:0]        bht_q        [BhtN];
  logic              btb_valid_q  [BtbN];
  logic [TagW-1:0]   btb_tag_q    [BtbN];
  logic [31:0]       btb_target_q [BtbN];

  logic [BHT_DEPTH-1:0] pred_bht_idx, upd_bht_idx;
  logic [BTB_DEPTH-1:0] pred_btb_idx, upd_btb_idx;
  logic                 pred_fire, pred_hit;
  logic                 sweep_bht, sweep_btb;
  logic [1:0]           ctr_cur, ctr_d;
  logic                 unused_pc_lsb;

  assign pred_bht_idx = pred_pc_i[BHT_DEPTH:1];
  assign pred_btb_idx = pred_pc_i[BTB_DEPTH:1];
  assign upd_bht_idx  = upd_pc_i[BHT_DEPTH:1];
  assign upd_btb_idx  = upd_pc_i[BTB_DEPTH:1];
  assign unused_pc_lsb = pred_pc_i[0] ^ upd_pc_i[0];

  assign pred_ready_o     = (state_q == StRun);
  assign pred_fire        = pred_valid_i && pred_ready_o;
  assign pred_hit         = btb_valid_q[pred_btb_idx] &&
                            (btb_tag_q[pred_btb_idx] == pred_pc_i[31:BTB_DEPTH+1]);
  assign pred_out_valid_o = pred_out_valid_q;
  assign pred_taken_o     = pred_taken_q;
  assign pred_target_o    = pred_target_q;

  // The sweep runs over the larger table; the smaller one is only written while in range.
  assign sweep_bht = (32'(cnt_q) < BhtN);
  assign sweep_btb = (32'(cnt_q) < BtbN);

  always_comb begin
    ctr_cur = bht_q[upd_bht_idx];
    ctr_d   = ctr_cur;
    if (upd_taken_i) begin
      if (ctr_cur != 2'b11) ctr_d = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_d = ctr_cur - 2'b01;
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= StInit;
      cnt_q            <= '0;
      pred_out_valid_q <= 1'b0;
      pred_taken_q     <= 1'b0;
      pred_target_q    <= 32'h0;
    end else begin
      case (state_q)
        StInit: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == {CntW{1'b1}}) state_q <= StRun;
        end
        StRun:   state_q <= StRun;
        default: state_q <= StInit;
      endcase
      pred_out_valid_q <= pred_fire;
      pred_taken_q     <= pred_fire && pred_hit && bht_q[pred_bht_idx][1];
      pred_target_q    <= (pred_fire && pred_hit) ? btb_target_q[pred_btb_idx] : 32'h0;
    end
  end

  // Table storage needs no reset: the sweep clears it before any read is served.
  always_ff @(posedge clock_i) begin
    if (state_q == StInit) begin
      if (sweep_bht) bht_q[cnt_q[BHT_DEPTH-1:0]] <= 2'b01;
      if (sweep_btb) btb_valid_q[cnt_q[BTB_DEPTH-1:0]] <= 1'b0;
    end else if (upd_valid_i) begin
      bht_q[upd_bht_idx] <= ctr_d;
      if (upd_taken_i) begin
        btb_valid_q[upd_btb_idx]  <= 1'b1;
        btb_tag_q[upd_btb_idx]    <= upd_pc_i[31:BTB_DEPTH+1];
        btb_target_q[upd_btb_idx] <= upd_target_i;
      end
    end
  end

endmodule

// File: tb/tb_bpred.sv
// Self-checking bench for bpred: directed test-plan sequences with literal expectations,
// then randomized traffic checked every cycle against a behavioural table model.
module tb_bpred;

  logic        clock = 1'b0;
  logic        reset;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_ready;
  logic        pred_out_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;

  int checks = 0;
  int errors = 0;

  bpred #(.BHT_DEPTH(6), .BTB_DEPTH(5)) dut (
    .clock_i         (clock),
    .reset_i         (reset),
    .pred_valid_i    (pred_valid),
    .pred_pc_i       (pred_pc),
    .pred_ready_o    (pred_ready),
    .pred_out_valid_o(pred_out_valid),
    .pred_taken_o    (pred_taken),
    .pred_target_o   (pred_target),
    .upd_valid_i     (upd_valid),
    .upd_pc_i        (upd_pc),
    .upd_taken_i     (upd_taken),
    .upd_target_i    (upd_target)
  );

  always #5 clock = ~clock;

  // Behavioural model: plain arrays indexed with modulo arithmetic on the PC.
  int          m_sweep;
  int          m_ctr [64];
  bit          m_v   [32];
  int unsigned m_tag [32];
  logic [31:0] m_tgt [32];
  logic        e_valid, e_taken;
  logic [31:0] e_tgt;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_sweep = 0;
      e_valid = 0; e_taken = 0; e_tgt = 0;
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      for (int i = 0; i < 32; i++) m_v[i] = 0;
    end else if (m_sweep < 64) begin
      m_sweep = m_sweep + 1;
      e_valid = 0; e_taken = 0; e_tgt = 0;
    end else begin
      int bi, ti, ui, uti;
      bit hit;
      bi  = (pred_pc >> 1) % 64;
      ti  = (pred_pc >> 1) % 32;
      hit = m_v[ti] && (m_tag[ti] == (pred_pc >> 6));
      e_valid = pred_valid;
      e_taken = pred_valid && hit && (m_ctr[bi] >= 2);
      e_tgt   = (pred_valid && hit) ? m_tgt[ti] : 32'h0;
      if (upd_valid) begin
        ui  = (upd_pc >> 1) % 64;
        uti = (upd_pc >> 1) % 32;
        if (upd_taken) begin
          if (m_ctr[ui] < 3) m_ctr[ui] = m_ctr[ui] + 1;
          m_v[uti]   = 1;
          m_tag[uti] = upd_pc >> 6;
          m_tgt[uti] = upd_target;
        end else if (m_ctr[ui] > 0) begin
          m_ctr[ui] = m_ctr[ui] - 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    chk("model ready", {31'b0, pred_ready}, {31'b0, (m_sweep == 64) && !reset});
    chk("model out_valid", {31'b0, pred_out_valid}, {31'b0, e_valid});
    chk("model taken", {31'b0, pred_taken}, {31'b0, e_taken});
    chk("model target", pred_target, e_tgt);
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    pred_valid = 0; pred_pc = 0; upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
  endtask

  task automatic req(input logic [31:0] pc, input logic et, input logic [31:0] etg,
                     input string nm);
    pred_valid = 1; pred_pc = pc;
    cyc();
    pred_valid = 0;
    chk({nm, " valid"}, {31'b0, pred_out_valid}, 32'd1);
    chk({nm, " taken"}, {31'b0, pred_taken}, {31'b0, et});
    chk({nm, " target"}, pred_target, etg);
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic [31:0] tg);
    upd_valid = 1; upd_pc = pc; upd_taken = t; upd_target = tg;
    cyc();
    upd_valid = 0;
  endtask

  task automatic sweep_check(input string nm);
    for (int i = 0; i < 64; i++) begin
      chk({nm, " ready low"}, {31'b0, pred_ready}, 32'd0);
      pred_valid = 1'($urandom);
      pred_pc    = 32'h8000_0010;
      upd_valid  = 1'($urandom);
      upd_pc     = 32'h8000_0010;
      upd_taken  = 1;
      upd_target = 32'h8000_0100;
      cyc();
    end
    idle();
    chk({nm, " ready high"}, {31'b0, pred_ready}, 32'd1);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] b;
    case ($urandom_range(0, 2))
      0:       b = 32'h8000_0000;
      1:       b = 32'h8000_1000;
      default: b = 32'h0040_0000;
    endcase
    return b + 32'($urandom_range(0, 63) << 1);
  endfunction

  initial begin
    idle();
    reset = 1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset ready", {31'b0, pred_ready}, 32'd0);
    chk("reset valid", {31'b0, pred_out_valid}, 32'd0);
    chk("reset target", pred_target, 32'd0);
    reset = 0;
    sweep_check("init");

    req(32'h8000_0010, 0, 32'h0, "cold");
    upd(32'h8000_0010, 1, 32'h8000_0100);
    req(32'h8000_0010, 1, 32'h8000_0100, "trained");
    upd(32'h8000_0010, 0, 32'h0);
    req(32'h8000_0010, 0, 32'h8000_0100, "one not-taken");
    repeat (4) upd(32'h8000_0010, 1, 32'h8000_0100);
    upd(32'h8000_0010, 0, 32'h0);
    req(32'h8000_0010, 1, 32'h8000_0100, "saturated");

    req(32'h8000_0050, 0, 32'h0, "alias miss");
    upd(32'h8000_0050, 1, 32'h8000_0200);
    req(32'h8000_0010, 0, 32'h0, "evicted");
    req(32'h8000_0050, 1, 32'h8000_0200, "alias hit");

    upd(32'h8000_0010, 1, 32'h8000_0100);
    pred_valid = 1; pred_pc = 32'h8000_0010;
    cyc();
    pred_valid = 0;
    chk("pre-reset valid", {31'b0, pred_out_valid}, 32'd1);
    chk("pre-reset taken", {31'b0, pred_taken}, 32'd1);
    reset = 1;
    #1;
    chk("async reset valid", {31'b0, pred_out_valid}, 32'd0);
    chk("async reset taken", {31'b0, pred_taken}, 32'd0);
    chk("async reset target", pred_target, 32'd0);
    chk("async reset ready", {31'b0, pred_ready}, 32'd0);
    cyc();
    reset = 0;
    sweep_check("resweep");
    req(32'h8000_0010, 0, 32'h0, "training lost");

    pred_valid = 1; pred_pc = 32'h8000_0010;
    upd_valid = 1; upd_pc = 32'h8000_0010; upd_taken = 1; upd_target = 32'h8000_0100;
    cyc();
    idle();
    chk("rbw same taken", {31'b0, pred_taken}, 32'd0);
    chk("rbw same target", pred_target, 32'd0);
    req(32'h8000_0010, 1, 32'h8000_0100, "rbw next");

    for (int i = 0; i < 3000; i++) begin
      pred_valid = ($urandom_range(0, 3) != 0);
      pred_pc    = rand_pc();
      upd_valid  = ($urandom_range(0, 2) == 0);
      upd_pc     = ($urandom_range(0, 3) == 0) ? pred_pc : rand_pc();
      upd_taken  = 1'($urandom);
      upd_target = $urandom & 32'hFFFF_FFFE;
      cyc();
    end
    idle();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
